mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage: scalar/vector load-store through a byte-wide data memory, one element per cycle.
// Define MEM_WRAP_ERR_EN to add err_o, flagging address wrap-around and the reserved opcode.
module mem_stage #(
    parameter int REGI_BITS  = 4,
    parameter int VECT_BITS  = 2,
    parameter int MEMO_LINES = 64,
    parameter int REGI_SIZE  = 16,
    parameter int VECT_SIZE  = 8,
    parameter int ELEM_SIZE  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [2:0]                     op_i,
    input  logic [REGI_SIZE-1:0]           ialu_res_i,
    input  logic [REGI_SIZE-1:0]           iswa_res_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] vswa_res_i,
    input  logic [REGI_BITS-1:0]           rd_i,
    input  logic [VECT_BITS-1:0]           vd_i,
    output logic                           valid_o,
    output logic [REGI_SIZE-1:0]           ires_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0] vres_o,
    output logic [REGI_BITS-1:0]           rd_o,
    output logic [VECT_BITS-1:0]           vd_o,
    output logic                           iwe_o,
    output logic                           vwe_o
`ifdef MEM_WRAP_ERR_EN
    ,output logic                          err_o
`endif
);
    localparam int AW = $clog2(MEMO_LINES);
    localparam int VW = ELEM_SIZE * VECT_SIZE;
    localparam int CW = $clog2(VECT_SIZE + 1);
    localparam logic [AW:0] LINES = (AW+1)'(MEMO_LINES);

    localparam logic [2:0] OP_IPASS = 3'd1, OP_VPASS = 3'd2, OP_SLD = 3'd3,
                           OP_SST = 3'd4, OP_VLD = 3'd5, OP_VST = 3'd6, OP_RSV = 3'd7;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    function automatic logic [CW-1:0] elem_count(input logic [2:0] op);
        case (op)
            OP_SLD, OP_SST: return CW'(2);
            OP_VLD, OP_VST: return CW'(VECT_SIZE);
            default:        return '0;
        endcase
    endfunction

    state_t                 state, state_nxt;
    logic [2:0]             op_r;
    logic [AW-1:0]          addr_r;
    logic [REGI_SIZE-1:0]   iswa_r;
    logic [VW-1:0]          vswa_r, ld_buf, ld_nxt, st_vec;
    logic [REGI_BITS-1:0]   rd_r;
    logic [VECT_BITS-1:0]   vd_r;
    logic [CW-1:0]          cnt, n_r;
    logic [AW:0]            addr_sum;
    logic [AW-1:0]          addr_cur;
    logic [ELEM_SIZE-1:0]   wdata, rdata;
    logic                   accept, enter_done, is_store, is_load;

    // No reset on the array: contents survive rst_i.
    logic [ELEM_SIZE-1:0]   mem [MEMO_LINES];

    assign ready_o    = (state == IDLE);
    assign valid_o    = (state == DONE);
    assign accept     = ready_o && valid_i;
    assign enter_done = (state_nxt == DONE) && (state != DONE);
    assign is_store   = (op_r == OP_SST) || (op_r == OP_VST);
    assign is_load    = (op_r == OP_SLD) || (op_r == OP_VLD);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (valid_i) state_nxt = (elem_count(op_i) == '0) ? DONE : XFER;
            XFER: if (cnt == n_r - CW'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Element address modulo MEMO_LINES (also correct for non-power-of-two depths).
    always_comb begin
        addr_sum = {1'b0, addr_r} + (AW+1)'(cnt);
        addr_cur = (addr_sum >= LINES) ? AW'(addr_sum - LINES) : addr_sum[AW-1:0];
    end

    always_comb begin
        st_vec = (op_r == OP_SST) ? VW'(iswa_r) : vswa_r;
        wdata  = st_vec[cnt*ELEM_SIZE +: ELEM_SIZE];
        rdata  = mem[addr_cur];
        ld_nxt = ld_buf;
        ld_nxt[cnt*ELEM_SIZE +: ELEM_SIZE] = rdata;
    end

    always_ff @(posedge clk_i) begin
        if (state == XFER && is_store) mem[addr_cur] <= wdata;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            n_r    <= '0;
            op_r   <= '0;
            addr_r <= '0;
            iswa_r <= '0;
            vswa_r <= '0;
            rd_r   <= '0;
            vd_r   <= '0;
            ld_buf <= '0;
            ires_o <= '0;
            vres_o <= '0;
            rd_o   <= '0;
            vd_o   <= '0;
            iwe_o  <= 1'b0;
            vwe_o  <= 1'b0;
        end else begin
            state <= state_nxt;
            iwe_o <= 1'b0;
            vwe_o <= 1'b0;
            if (accept) begin
                op_r   <= op_i;
                n_r    <= elem_count(op_i);
                addr_r <= ialu_res_i[AW-1:0];
                iswa_r <= iswa_res_i;
                vswa_r <= vswa_res_i;
                rd_r   <= rd_i;
                vd_r   <= vd_i;
                cnt    <= '0;
                ld_buf <= '0;
            end else if (state == XFER) begin
                cnt <= cnt + CW'(1);
                if (is_load) ld_buf <= ld_nxt;
            end
            // Zero-length ops finish on the accept edge straight from the inputs.
            if (enter_done) begin
                if (state == IDLE) begin
                    rd_o <= rd_i;
                    vd_o <= vd_i;
                    if (op_i == OP_IPASS) begin ires_o <= ialu_res_i; iwe_o <= 1'b1; end
                    if (op_i == OP_VPASS) begin vres_o <= valu_res_i; vwe_o <= 1'b1; end
                end else begin
                    rd_o <= rd_r;
                    vd_o <= vd_r;
                    if (op_r == OP_SLD) begin ires_o <= ld_nxt[REGI_SIZE-1:0]; iwe_o <= 1'b1; end
                    if (op_r == OP_VLD) begin vres_o <= ld_nxt; vwe_o <= 1'b1; end
                end
            end
        end
    end

`ifdef MEM_WRAP_ERR_EN
    logic        err_r, err_now;
    logic [AW:0] last_addr;

    always_comb begin
        last_addr = {1'b0, ialu_res_i[AW-1:0]} + (AW+1)'(elem_count(op_i)) - (AW+1)'(1);
        err_now   = (op_i == OP_RSV) || ((elem_count(op_i) != '0) && (last_addr >= LINES));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_r <= 1'b0;
            err_o <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (accept) err_r <= err_now;
            if (enter_done) err_o <= (state == IDLE) ? err_now : err_r;
        end
    end
`endif

endmodule
